// File: rtl/hack_decode_queue.sv
// Hack CPU decode stage: instructions are decoded once on enqueue and
// held in a small FIFO of control bundles until execute takes them.
module hack_decode_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_is_c,
  output logic [WIDTH-1:0]         out_imm,
  output logic                     out_load_a,
  output logic                     out_load_d,
  output logic                     out_write_m,
  output logic                     out_sel_am,
  output logic [5:0]               out_alu,
  output logic [2:0]               out_jump,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         decoded_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic             is_c;
    logic [WIDTH-1:0] imm;
    logic             load_a;
    logic             load_d;
    logic             write_m;
    logic             sel_am;
    logic [5:0]       alu;
    logic [2:0]       jump;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec;
  entry_t          head;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW:0]     count;
  logic            push;
  logic            pop;
  logic            c;

  assign c = in_inst[WIDTH-1];

  always_comb begin
    dec = '0;
    dec.is_c = c;
    if (c) begin
      dec.load_a  = in_inst[5];
      dec.load_d  = in_inst[4];
      dec.write_m = in_inst[3];
      dec.sel_am  = in_inst[12];
      dec.alu     = in_inst[11:6];
      dec.jump    = in_inst[2:0];
    end else begin
      dec.imm    = {1'b0, in_inst[WIDTH-2:0]};
      dec.load_a = 1'b1;
    end
  end

  // in_ready looks only at occupancy, so a full queue never
  // accepts even when the head leaves in the same cycle.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occupancy = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decoded_count <= '0;
    end else if (pop && !flush && decoded_count != '1) begin
      decoded_count <= decoded_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= dec;
  end

  // Gate the head so stale or unwritten storage never reaches execute.
  assign head = out_valid ? mem[rd_ptr] : '0;

  assign out_is_c    = head.is_c;
  assign out_imm     = head.imm;
  assign out_load_a  = head.load_a;
  assign out_load_d  = head.load_d;
  assign out_write_m = head.write_m;
  assign out_sel_am  = head.sel_am;
  assign out_alu     = head.alu;
  assign out_jump    = head.jump;

endmodule

// File: tb/tb_hack_decode_queue.sv
// Bench for hack_decode_queue: table vectors, scoreboard, and
// hand sequences for full, flush, saturation and reset.
module tb_hack_decode_queue;

  typedef logic [29:0] bundle_t;

  typedef struct {
    logic [15:0] inst;
    bundle_t     exp;
  } vec_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 0;
  logic        out_is_c;
  logic [15:0] out_imm;
  logic        out_load_a;
  logic        out_load_d;
  logic        out_write_m;
  logic        out_sel_am;
  logic [5:0]  out_alu;
  logic [2:0]  out_jump;
  logic [2:0]  occupancy;
  logic [2:0]  decoded_count;

  int      total = 0;
  int      bad = 0;
  bundle_t cur_exp = '0;
  bundle_t sb[$];
  int      cnt_m = 0;
  vec_t    tab[8];

  hack_decode_queue #(.WIDTH(16), .DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_is_c(out_is_c), .out_imm(out_imm),
    .out_load_a(out_load_a), .out_load_d(out_load_d),
    .out_write_m(out_write_m), .out_sel_am(out_sel_am),
    .out_alu(out_alu), .out_jump(out_jump),
    .occupancy(occupancy), .decoded_count(decoded_count)
  );

  always #5 clk = ~clk;

  wire bundle_t act = {out_is_c, out_imm, out_load_a, out_load_d,
                       out_write_m, out_sel_am, out_alu, out_jump};

  function automatic bundle_t mk(logic ic, logic [15:0] im,
                                 logic la, logic ld, logic wm,
                                 logic sa, logic [5:0] al,
                                 logic [2:0] jp);
    return {ic, im, la, ld, wm, sa, al, jp};
  endfunction

  function automatic bundle_t model(logic [15:0] i);
    if (!i[15]) return mk(0, {1'b0, i[14:0]}, 1, 0, 0, 0, 0, 0);
    return mk(1, 16'h0, i[5], i[4], i[3], i[12], i[11:6], i[2:0]);
  endfunction

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      cnt_m = 0;
    end else begin
      chk("occupancy", 64'(occupancy), 64'(sb.size()));
      chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(sb.size() != 4));
      chk("count", 64'(decoded_count), 64'(cnt_m));
      if (!out_valid) chk("gated", 64'(act), 64'(0));
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("underflow", 64'(out_valid), 64'(0));
          end else begin
            chk("head", 64'(act), 64'(sb.pop_front()));
            if (cnt_m != 7) cnt_m++;
          end
        end
        if (in_valid && in_ready) sb.push_back(cur_exp);
      end
    end
  end

  task automatic send(input logic [15:0] i, input bundle_t e);
    int  n;
    logic acc;
    n = 0;
    acc = 0;
    in_valid = 1;
    in_inst = i;
    cur_exp = e;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready && !flush && !rst;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accept", 64'(acc), 64'(1));
    in_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1;
    while (occupancy != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 64'(occupancy), 64'(0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    logic [15:0] r;
    int saved;
    tab[0] = '{16'h0005, mk(0, 16'h0005, 1, 0, 0, 0, 6'b000000, 3'b000)};
    tab[1] = '{16'hEC10, mk(1, 16'h0000, 0, 1, 0, 0, 6'b110000, 3'b000)};
    tab[2] = '{16'hFC88, mk(1, 16'h0000, 0, 0, 1, 1, 6'b110010, 3'b000)};
    tab[3] = '{16'hE302, mk(1, 16'h0000, 0, 0, 0, 0, 6'b001100, 3'b010)};
    tab[4] = '{16'h7FFF, mk(0, 16'h7FFF, 1, 0, 0, 0, 6'b000000, 3'b000)};
    tab[5] = '{16'hFFFF, mk(1, 16'h0000, 1, 1, 1, 1, 6'b111111, 3'b111)};
    tab[6] = '{16'hA0E8, mk(1, 16'h0000, 1, 0, 1, 0, 6'b000011, 3'b000)};
    tab[7] = '{16'h0000, mk(0, 16'h0000, 1, 0, 0, 0, 6'b000000, 3'b000)};

    #12;
    chk("rst_occ", 64'(occupancy), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(1));
    chk("rst_cnt", 64'(decoded_count), 64'(0));
    chk("rst_fields", 64'(act), 64'(0));
    @(posedge clk);
    #1;
    rst = 0;

    // single A-instruction, one-cycle latency
    out_ready = 1;
    send(tab[0].inst, tab[0].exp);
    chk("lat_valid", 64'(out_valid), 64'(1));
    chk("lat_head", 64'(act), 64'(tab[0].exp));
    @(posedge clk);
    #1;
    chk("cnt_one", 64'(decoded_count), 64'(1));

    // stream the table back-to-back
    for (int k = 1; k < 8; k++) send(tab[k].inst, tab[k].exp);
    drain();

    // fill to DEPTH, fifth held upstream, then release across wrap
    out_ready = 0;
    for (int k = 0; k < 4; k++) send(tab[k+2].inst, tab[k+2].exp);
    in_valid = 1;
    in_inst = tab[7].inst;
    cur_exp = tab[7].exp;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("full_occ", 64'(occupancy), 64'(4));
    chk("full_ready", 64'(in_ready), 64'(0));
    out_ready = 1;
    send(tab[7].inst, tab[7].exp);
    drain();

    // flush at occupancy 3 with push and pop requested
    out_ready = 0;
    for (int k = 0; k < 3; k++) send(tab[k].inst, tab[k].exp);
    chk("pre_flush", 64'(occupancy), 64'(3));
    saved = cnt_m;
    flush = 1;
    in_valid = 1;
    in_inst = 16'h1234;
    cur_exp = model(16'h1234);
    out_ready = 1;
    @(posedge clk);
    #1;
    flush = 0;
    in_valid = 0;
    out_ready = 0;
    chk("flush_occ", 64'(occupancy), 64'(0));
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_cnt", 64'(decoded_count), 64'(saved));

    // random traffic checked by the scoreboard
    for (int k = 0; k < 200; k++) begin
      r = 16'($urandom);
      in_valid = 1'($urandom);
      in_inst = r;
      cur_exp = model(r);
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    drain();

    // saturation from zero after reset
    do_reset();
    out_ready = 1;
    for (int k = 0; k < 9; k++) send(tab[k%8].inst, tab[k%8].exp);
    drain();
    chk("sat_cnt", 64'(decoded_count), 64'(7));

    // asynchronous reset with two entries queued
    out_ready = 0;
    send(tab[1].inst, tab[1].exp);
    send(tab[2].inst, tab[2].exp);
    chk("pre_rst_occ", 64'(occupancy), 64'(2));
    #2;
    rst = 1;
    #1;
    chk("arst_occ", 64'(occupancy), 64'(0));
    chk("arst_cnt", 64'(decoded_count), 64'(0));
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_ready", 64'(in_ready), 64'(1));
    chk("arst_fields", 64'(act), 64'(0));
    @(posedge clk);
    #1;
    rst = 0;
    out_ready = 1;
    send(tab[5].inst, tab[5].exp);
    chk("post_rst_head", 64'(act), 64'(tab[5].exp));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/hack_decode_queue.md
Name: hack_decode_queue

Overview:
- Registered, buffered instruction-decode stage for the Hack CPU front end.
- Accepts raw instructions over a valid/ready handshake and decodes them once, at enqueue.
- Holds decoded control bundles in a DEPTH-entry FIFO and presents the oldest to the execute stage over a second valid/ready handshake.
- Generalises the combinational decoder with instruction width, buffering, flush, A-instruction immediate output, and a saturating decode counter.

Parameters:
- WIDTH, 16: instruction width. Must be ≥16. Bit WIDTH-1 is the A/C type bit. C-fields occupy bits 12..0 in the standard Hack layout.
- DEPTH, 2: FIFO entries. Power of two, ≥2.
- CNT_W, 16: width of the decoded-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all queued entries.
- in_valid  in  1  in_inst is valid.
- in_ready  out  1  queue can accept an instruction.
- in_inst  in  WIDTH  raw instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head entry.
- out_is_c  out  1  head is a C-instruction.
- out_imm  out  WIDTH  A-instruction immediate, zero-extended; 0 for C.
- out_load_a  out  1  write A register.
- out_load_d  out  1  write D register.
- out_write_m  out  1  write memory.
- out_sel_am  out  1  ALU y-operand select: 1 = M, 0 = A.
- out_alu  out  6  zx,nx,zy,ny,f,no (inst[11:6]).
- out_jump  out  3  j1,j2,j3 (inst[2:0]).
- occupancy  out  $clog2(DEPTH)+1  entries currently held.
- decoded_count  out  CNT_W  completed output handshakes, saturating.

Behaviour:
- Decode rules, with c = inst[WIDTH-1]:
  - is_c = c
  - imm = c ? 0 : {1'b0, inst[WIDTH-2:0]}
  - load_a = ~c | inst[5]
  - load_d = c & inst[4]
  - write_m = c & inst[3]
  - sel_am = c & inst[12]
  - alu = c ? inst[11:6] : 0
  - jump = c ? inst[2:0] : 0
  - Bits WIDTH-2..13 are ignored for C-instructions.
- Push and pop:
  - Push occurs when in_valid & in_ready.
  - Pop occurs when out_valid & out_ready.
  - in_ready = (occupancy != DEPTH). It has no combinational dependence on out_ready: when full, no push is accepted even if a pop occurs in the same cycle.
  - out_valid = (occupancy != 0).
  - The out_* fields are driven directly from the head entry storage.
  - When out_valid=0, the out_* fields are all 0.
- Latency: an instruction pushed in cycle N is visible at the head no earlier than cycle N+1. There is no same-cycle bypass.
- Ordering: strict FIFO.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push and pop in the same cycle: both take effect and occupancy is unchanged. This includes occupancy=1, where the new entry becomes the head next cycle.
- Empty queue: a pop is impossible. Occupancy never underflows.
- Full queue: a push is impossible. Holding in_valid=1 keeps the instruction pending upstream; the instruction is not lost.
- Flush:
  - Next cycle, occupancy=0 and both pointers are 0.
  - Flush overrides any push or pop in the same cycle: that push is dropped and that pop is not counted.
  - in_ready during a flush cycle follows the pre-flush occupancy.
- decoded_count:
  - Increments by 1 on each counted pop.
  - Holds at 2^CNT_W-1 once reached.
  - Not cleared by flush.
- Reset (asynchronous, any time, including mid-transfer):
  - occupancy=0, pointers=0, decoded_count=0.
  - Outputs: out_valid=0, all out_* fields 0, in_ready=1.
  - Storage contents need not be reset.
- No X propagation: the out_* fields are gated by out_valid.

Test Plan:
- Push 0x0005, out_ready=1 → next cycle out_valid=1, is_c=0, imm=0x0005, load_a=1, load_d=0, write_m=0, jump=000. Then decoded_count=1.
- Push 0xEC10 (D=A) → is_c=1, sel_am=0, alu=110000, load_d=1, load_a=0, write_m=0, jump=000, imm=0.
- Push 0xFC88 (M=M-1), then 0xE302 (D;JEQ-class, jump=010) back-to-back → both appear in order with out_alu=110010, write_m=1, sel_am=1, then jump=010.
- DEPTH=4, out_ready=0, push 5 instructions → in_ready=0 after the 4th and occupancy=4. The 5th is held. Raise out_ready → the 5th is accepted and order is preserved across pointer wrap.
- Occupancy=3, assert flush together with in_valid=1 and out_ready=1 → next cycle occupancy=0, out_valid=0, decoded_count unchanged.
- CNT_W=3, complete 9 pops → decoded_count saturates at 7. Assert rst mid-stream with occupancy=2 → occupancy, decoded_count and out_valid read 0 immediately, and in_ready=1.
